op_logic_shift: RTL

Parametrised, pipelined logic/shift execution unit for the Cortex-M0 datapath. It performs AND, ORR, EOR, BIC, MVN and MOV on a register operand and a shifted-register or immediate second operand, and generates NZC flags. It extends the single-function XOR unit in four ways: a selectable opcode, a full ARM shifter (LSL/LSR/ASR/ROR/RRX) applied to operand 2, a two-stage valid/ready pipeline with backpressure, and a parametrised data width.

---
 rtl/op_logic_shift_pkg.sv | 35 +++
 rtl/op_logic_shift_if.sv | 41 ++++
 rtl/op_shifter.sv | 69 ++++++
 rtl/op_logic_shift.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/op_logic_shift_pkg.sv
// Shared opcode/shift-type codes and stage-1 control payload for the logic/shift unit.
package op_logic_shift_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_ORR  = 3'd1,
        OP_EOR  = 3'd2,
        OP_BIC  = 3'd3,
        OP_MVN  = 3'd4,
        OP_MOV  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_e;

    // Control fields carried from acceptance into the result stage.
    typedef struct packed {
        op_e  op;
        logic s;
        logic carry;
        logic zero;
        logic neg;
    } ctrl_t;

    function automatic logic op_reserved(input op_e op);
        return (op == OP_RSV6) || (op == OP_RSV7);
    endfunction

endpackage

// File: rtl/op_logic_shift_if.sv
// Valid/ready request and result channel of the logic/shift execution unit.
interface op_logic_shift_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IMM_W = 12
);
    localparam int unsigned SH_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             IMM;
    logic             S;
    logic [WIDTH-1:0] Rn;
    logic [WIDTH-1:0] Rm;
    logic [IMM_W-1:0] imm_operand;
    logic [SH_W-1:0]  imm_shift;
    logic [1:0]       stype;
    logic             carry_in;
    logic             zero_in;
    logic             neg_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Rd;
    logic             carry_out;
    logic             zero_out;
    logic             neg_out;
    logic             op_err;

    modport master (
        output in_valid, op, IMM, S, Rn, Rm, imm_operand, imm_shift, stype,
               carry_in, zero_in, neg_in, out_ready,
        input  in_ready, out_valid, Rd, carry_out, zero_out, neg_out, op_err
    );

    modport slave (
        input  in_valid, op, IMM, S, Rn, Rm, imm_operand, imm_shift, stype,
               carry_in, zero_in, neg_in, out_ready,
        output in_ready, out_valid, Rd, carry_out, zero_out, neg_out, op_err
    );

endinterface

// File: rtl/op_shifter.sv
// Combinational ARM-style barrel shifter with carry-out (LSL/LSR/ASR/ROR/RRX).
module op_shifter
    import op_logic_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SH_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [SH_W-1:0]  amount,
    input  shift_e           stype,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result_c,
    output logic             carry_c
);

    logic [SH_W-1:0]  inv_idx;
    logic [SH_W-1:0]  lsb_idx;
    logic [WIDTH-1:0] ror_val;
    logic             amt_zero;

    // WIDTH is a power of two, so (0 - n) in SH_W bits is exactly WIDTH-n.
    assign inv_idx  = SH_W'(0) - amount;
    assign lsb_idx  = amount - SH_W'(1);
    assign ror_val  = (value >> amount) | (value << inv_idx);
    assign amt_zero = (amount == '0);

    // A zero amount selects the special encodings: LSR/ASR #WIDTH and RRX.
    always_comb begin
        result_c = value;
        carry_c  = carry_in;
        case (stype)
            SH_LSL: begin
                if (!amt_zero) begin
                    result_c = value << amount;
                    carry_c  = value[inv_idx];
                end
            end
            SH_LSR: begin
                if (amt_zero) begin
                    result_c = '0;
                    carry_c  = value[WIDTH-1];
                end else begin
                    result_c = value >> amount;
                    carry_c  = value[lsb_idx];
                end
            end
            SH_ASR: begin
                if (amt_zero) begin
                    result_c = {WIDTH{value[WIDTH-1]}};
                    carry_c  = value[WIDTH-1];
                end else begin
                    result_c = $signed(value) >>> amount;
                    carry_c  = value[lsb_idx];
                end
            end
            SH_ROR: begin
                if (amt_zero) begin
                    result_c = {carry_in, value[WIDTH-1:1]};
                    carry_c  = value[0];
                end else begin
                    result_c = ror_val;
                    carry_c  = ror_val[WIDTH-1];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/op_logic_shift.sv
// Two-stage valid/ready logic/shift execution unit: AND/ORR/EOR/BIC/MVN/MOV with NZC flags.
module op_logic_shift
    import op_logic_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IMM_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    op_logic_shift_if.slave  bus
);

    logic [WIDTH-1:0] shift_res_c;
    logic             shift_carry_c;
    logic [WIDTH-1:0] op2_c;
    logic             op2_carry_c;
    logic             s2_adv_c;
    logic             s1_adv_c;
    logic             accept_c;

    logic             s1_valid, s1_valid_d;
    logic [WIDTH-1:0] s1_rn, s1_rn_d;
    logic [WIDTH-1:0] s1_op2, s1_op2_d;
    logic             s1_carry, s1_carry_d;
    ctrl_t            s1_ctrl, s1_ctrl_d;

    logic             s2_valid, s2_valid_d;
    logic [WIDTH-1:0] s2_rd, s2_rd_d;
    logic             s2_c, s2_c_d;
    logic             s2_z, s2_z_d;
    logic             s2_n, s2_n_d;
    logic             s2_err, s2_err_d;
    logic [WIDTH-1:0] res_c;

    op_shifter #(.WIDTH(WIDTH)) u_shifter (
        .value    (bus.Rm),
        .amount   (bus.imm_shift),
        .stype    (shift_e'(bus.stype)),
        .carry_in (bus.carry_in),
        .result_c (shift_res_c),
        .carry_c  (shift_carry_c)
    );

    assign op2_c       = bus.IMM ? WIDTH'(bus.imm_operand) : shift_res_c;
    assign op2_carry_c = bus.IMM ? bus.carry_in : shift_carry_c;

    // Handshake: in_ready depends on out_ready but never on in_valid.
    assign s2_adv_c     = !s2_valid || bus.out_ready;
    assign s1_adv_c     = !s1_valid || s2_adv_c;
    assign bus.in_ready = rst && s1_adv_c;
    assign accept_c     = bus.in_valid && bus.in_ready;

    always_comb begin
        s1_valid_d = s1_valid;
        s1_rn_d    = s1_rn;
        s1_op2_d   = s1_op2;
        s1_carry_d = s1_carry;
        s1_ctrl_d  = s1_ctrl;
        if (s1_adv_c) begin
            s1_valid_d = accept_c;
        end
        if (accept_c) begin
            s1_rn_d    = bus.Rn;
            s1_op2_d   = op2_c;
            s1_carry_d = op2_carry_c;
            s1_ctrl_d  = '{op: op_e'(bus.op), s: bus.S, carry: bus.carry_in,
                           zero: bus.zero_in, neg: bus.neg_in};
        end
    end

    always_comb begin
        res_c = '0;
        case (s1_ctrl.op)
            OP_AND:  res_c = s1_rn & s1_op2;
            OP_ORR:  res_c = s1_rn | s1_op2;
            OP_EOR:  res_c = s1_rn ^ s1_op2;
            OP_BIC:  res_c = s1_rn & ~s1_op2;
            OP_MVN:  res_c = ~s1_op2;
            OP_MOV:  res_c = s1_op2;
            default: res_c = '0;
        endcase
    end

    // Result stage: reserved opcodes give Rd=0 and pass the sampled flags through.
    always_comb begin
        s2_valid_d = s2_valid;
        s2_rd_d    = s2_rd;
        s2_c_d     = s2_c;
        s2_z_d     = s2_z;
        s2_n_d     = s2_n;
        s2_err_d   = s2_err;
        if (s2_adv_c) begin
            s2_valid_d = s1_valid;
            if (s1_valid) begin
                s2_rd_d  = res_c;
                s2_err_d = op_reserved(s1_ctrl.op);
                if (s1_ctrl.s && !op_reserved(s1_ctrl.op)) begin
                    s2_c_d = s1_carry;
                    s2_z_d = (res_c == '0);
                    s2_n_d = res_c[WIDTH-1];
                end else begin
                    s2_c_d = s1_ctrl.carry;
                    s2_z_d = s1_ctrl.zero;
                    s2_n_d = s1_ctrl.neg;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_rn    <= '0;
            s1_op2   <= '0;
            s1_carry <= 1'b0;
            s1_ctrl  <= '0;
            s2_valid <= 1'b0;
            s2_rd    <= '0;
            s2_c     <= 1'b0;
            s2_z     <= 1'b0;
            s2_n     <= 1'b0;
            s2_err   <= 1'b0;
        end else begin
            s1_valid <= s1_valid_d;
            s1_rn    <= s1_rn_d;
            s1_op2   <= s1_op2_d;
            s1_carry <= s1_carry_d;
            s1_ctrl  <= s1_ctrl_d;
            s2_valid <= s2_valid_d;
            s2_rd    <= s2_rd_d;
            s2_c     <= s2_c_d;
            s2_z     <= s2_z_d;
            s2_n     <= s2_n_d;
            s2_err   <= s2_err_d;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.Rd        = s2_rd;
    assign bus.carry_out = s2_c;
    assign bus.zero_out  = s2_z;
    assign bus.neg_out   = s2_n;
    assign bus.op_err    = s2_err;

endmodule
